scalar_rf_wb: RTL and testbench

Scalar register file and write-pending scoreboard that sits on the receiving end of the writeback stage's `wb_out`. It commits one writeback per cycle and serves two combinational read ports to issue. It tracks a busy bit and a speculation bit for every register so issue can stall on RAW hazards. Speculative pending writes are squashed on `branch_mispredict` and retired to non-speculative on `branch_correct`.

---
 rtl/datapath_pkg.sv | 15 +
 rtl/scalar_rf_wb_if.sv | 32 +++
 rtl/scalar_rf_wb_sb_busy_table.sv | 60 ++++++
 rtl/scalar_rf_wb.sv | 64 ++++++
 tb/tb_scalar_rf_wb.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types for the scalar pipeline: data word, register index and writeback bundle.
package datapath_pkg;

   localparam int unsigned NUM_SREGS = 32;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef struct packed {
      logic     wen;
      regbits_t reg_sel;
      word_t    wdat;
   } wb_t;

endpackage

// File: rtl/scalar_rf_wb_if.sv
// Pipeline-facing bundle of the scalar register file: writeback, dispatch, branch and read ports.
interface scalar_rf_wb_if;
   import datapath_pkg::*;

   wb_t                  wb_out;
   logic                 disp_valid;
   regbits_t             disp_rd;
   logic                 disp_spec;
   logic                 branch_mispredict;
   logic                 branch_correct;
   regbits_t             rs1_sel;
   regbits_t             rs2_sel;
   word_t                rs1_data;
   word_t                rs2_data;
   logic                 rs1_busy;
   logic                 rs2_busy;
   logic [NUM_SREGS-1:0] busy_mask;
   logic                 stale_drop;

   modport master (
      output wb_out, disp_valid, disp_rd, disp_spec, branch_mispredict, branch_correct,
             rs1_sel, rs2_sel,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_mask, stale_drop
   );

   modport slave (
      input  wb_out, disp_valid, disp_rd, disp_spec, branch_mispredict, branch_correct,
             rs1_sel, rs2_sel,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_mask, stale_drop
   );

endinterface

// File: rtl/scalar_rf_wb_sb_busy_table.sv
// Busy/speculation scoreboard: writeback clear, mispredict squash, retire, then dispatch set.
module sb_busy_table
   import datapath_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_wen,
   input  regbits_t             wb_sel,
   input  logic                 disp_valid,
   input  regbits_t             disp_rd,
   input  logic                 disp_spec,
   input  logic                 branch_mispredict,
   input  logic                 branch_correct,
   output logic [NUM_SREGS-1:0] busy_mask,
   output logic                 wb_hit
);

   logic [NUM_SREGS-1:0] busy_q, busy_d;
   logic [NUM_SREGS-1:0] spec_q, spec_d;

   always_comb begin
      busy_d = busy_q;
      spec_d = spec_q;
      wb_hit = wb_wen && (wb_sel != '0) && busy_q[wb_sel];

      if (wb_hit) begin
         busy_d[wb_sel] = 1'b0;
         spec_d[wb_sel] = 1'b0;
      end

      if (branch_mispredict) begin
         busy_d = busy_d & ~spec_q;
         spec_d = spec_d & ~spec_q;
      end else if (branch_correct) begin
         spec_d = '0;
      end

      // Applied last so a same-cycle dispatch overrides the writeback clear.
      if (disp_valid && (disp_rd != '0) && !branch_mispredict) begin
         busy_d[disp_rd] = 1'b1;
         spec_d[disp_rd] = disp_spec;
      end

      busy_d[0] = 1'b0;
      spec_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         spec_q <= '0;
      end else begin
         busy_q <= busy_d;
         spec_q <= spec_d;
      end
   end

   assign busy_mask = busy_q;

endmodule

// File: rtl/scalar_rf_wb.sv
// Scalar register file with write-pending scoreboard; SCALAR_RF_BYPASS_EN forwards the
// committing writeback to the read ports in the same cycle.
module scalar_rf_wb
   import datapath_pkg::*;
(
   input logic         CLK,
   input logic         RST,
   scalar_rf_wb_if.slave bus
);

   word_t                regs_q [NUM_SREGS];
   logic [NUM_SREGS-1:0] busy_mask;
   logic                 wb_hit;
   logic                 stale_drop_q, stale_drop_d;

   sb_busy_table u_busy_table (
      .clk               (CLK),
      .rst               (RST),
      .wb_wen            (bus.wb_out.wen),
      .wb_sel            (bus.wb_out.reg_sel),
      .disp_valid        (bus.disp_valid),
      .disp_rd           (bus.disp_rd),
      .disp_spec         (bus.disp_spec),
      .branch_mispredict (bus.branch_mispredict),
      .branch_correct    (bus.branch_correct),
      .busy_mask         (busy_mask),
      .wb_hit            (wb_hit)
   );

   assign stale_drop_d = bus.wb_out.wen && (bus.wb_out.reg_sel != '0) &&
                         !busy_mask[bus.wb_out.reg_sel];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_SREGS; i++) regs_q[i] <= '0;
         stale_drop_q <= 1'b0;
      end else begin
         if (wb_hit) regs_q[bus.wb_out.reg_sel] <= bus.wb_out.wdat;
         stale_drop_q <= stale_drop_d;
      end
   end

   always_comb begin
      bus.rs1_data = (bus.rs1_sel == '0) ? '0 : regs_q[bus.rs1_sel];
      bus.rs2_data = (bus.rs2_sel == '0) ? '0 : regs_q[bus.rs2_sel];
      bus.rs1_busy = busy_mask[bus.rs1_sel];
      bus.rs2_busy = busy_mask[bus.rs2_sel];
`ifdef SCALAR_RF_BYPASS_EN
      // wb_hit already excludes register 0.
      if (wb_hit && (bus.wb_out.reg_sel == bus.rs1_sel)) begin
         bus.rs1_data = bus.wb_out.wdat;
         bus.rs1_busy = bus.disp_valid && (bus.disp_rd == bus.rs1_sel);
      end
      if (wb_hit && (bus.wb_out.reg_sel == bus.rs2_sel)) begin
         bus.rs2_data = bus.wb_out.wdat;
         bus.rs2_busy = bus.disp_valid && (bus.disp_rd == bus.rs2_sel);
      end
`endif
   end

   assign bus.busy_mask  = busy_mask;
   assign bus.stale_drop = stale_drop_q;

endmodule

// File: tb/tb_scalar_rf_wb.sv
// Directed bench for scalar_rf_wb with hand-computed expectations.
module tb_scalar_rf_wb;
   import datapath_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   int   total = 0;
   int   bad   = 0;

   scalar_rf_wb_if bus ();

   scalar_rf_wb dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.wb_out            = '0;
      bus.disp_valid        = 1'b0;
      bus.disp_rd           = '0;
      bus.disp_spec         = 1'b0;
      bus.branch_mispredict = 1'b0;
      bus.branch_correct    = 1'b0;
   endtask

   task automatic disp(input int rd, input logic spec);
      bus.disp_valid = 1'b1;
      bus.disp_rd    = regbits_t'(rd);
      bus.disp_spec  = spec;
   endtask

   task automatic wb(input int rd, input logic [31:0] d);
      bus.wb_out.wen     = 1'b1;
      bus.wb_out.reg_sel = regbits_t'(rd);
      bus.wb_out.wdat    = d;
   endtask

   initial begin
      RST = 1'b1;
      idle();
      bus.rs1_sel = '0;
      bus.rs2_sel = '0;
      tick();
      tick();
      RST = 1'b0;
      #1;

      // Reset state
      for (int r = 1; r < 32; r++) begin
         bus.rs1_sel = regbits_t'(r);
         #1;
         chk($sformatf("reset_r%0d", r), bus.rs1_data, 32'h0);
      end
      chk("reset_busy_mask", bus.busy_mask, 32'h0);
      chk("reset_stale", {31'b0, bus.stale_drop}, 32'h0);

      // Dispatch r5, then write it back
      disp(5, 1'b0);
      tick();
      idle();
      bus.rs1_sel = 5;
      #1;
      chk("r5_busy", {31'b0, bus.rs1_busy}, 32'h1);
      chk("r5_mask", bus.busy_mask, 32'h0000_0020);
      wb(5, 32'hDEAD_BEEF);
      #1;
`ifdef SCALAR_RF_BYPASS_EN
      chk("r5_wb_cycle_data", bus.rs1_data, 32'hDEAD_BEEF);
      chk("r5_wb_cycle_busy", {31'b0, bus.rs1_busy}, 32'h0);
`else
      chk("r5_wb_cycle_data", bus.rs1_data, 32'h0);
      chk("r5_wb_cycle_busy", {31'b0, bus.rs1_busy}, 32'h1);
`endif
      tick();
      idle();
      #1;
      chk("r5_data", bus.rs1_data, 32'hDEAD_BEEF);
      chk("r5_busy_clr", {31'b0, bus.rs1_busy}, 32'h0);
      chk("r5_mask_clr", bus.busy_mask, 32'h0);
      chk("r5_no_stale", {31'b0, bus.stale_drop}, 32'h0);

      // Speculative r3, non-spec r4, then mispredict
      disp(3, 1'b1);
      tick();
      disp(4, 1'b0);
      tick();
      idle();
      chk("r3r4_mask", bus.busy_mask, 32'h0000_0018);
      bus.branch_mispredict = 1'b1;
      tick();
      idle();
      chk("squash_mask", bus.busy_mask, 32'h0000_0010);
      wb(3, 32'h3333_3333);
      tick();
      idle();
      bus.rs1_sel = 3;
      #1;
      chk("r3_stale", {31'b0, bus.stale_drop}, 32'h1);
      chk("r3_unchanged", bus.rs1_data, 32'h0);
      wb(4, 32'h44);
      tick();
      idle();
      bus.rs2_sel = 4;
      #1;
      chk("stale_pulse_end", {31'b0, bus.stale_drop}, 32'h0);
      chk("r4_data", bus.rs2_data, 32'h44);
      chk("r4_mask_clr", bus.busy_mask, 32'h0);

      // Retire r7 then mispredict: stays busy
      disp(7, 1'b1);
      tick();
      idle();
      bus.branch_correct = 1'b1;
      tick();
      idle();
      bus.branch_mispredict = 1'b1;
      tick();
      idle();
      chk("r7_retired_busy", bus.busy_mask, 32'h0000_0080);
      wb(7, 32'h12);
      tick();
      idle();
      bus.rs1_sel = 7;
      #1;
      chk("r7_data", bus.rs1_data, 32'h12);
      chk("r7_mask_clr", bus.busy_mask, 32'h0);

      // Same-cycle dispatch and writeback to busy r9; new producer is speculative
      disp(9, 1'b0);
      tick();
      disp(9, 1'b1);
      wb(9, 32'h55);
      tick();
      idle();
      bus.rs1_sel = 9;
      #1;
      chk("r9_data", bus.rs1_data, 32'h55);
      chk("r9_still_busy", bus.busy_mask, 32'h0000_0200);
      chk("r9_no_stale", {31'b0, bus.stale_drop}, 32'h0);
      bus.branch_mispredict = 1'b1;
      tick();
      idle();
      chk("r9_squashed", bus.busy_mask, 32'h0);
      #1;
      chk("r9_data_kept", bus.rs1_data, 32'h55);

      // Bypass behaviour on rs2 for r2
      disp(2, 1'b0);
      tick();
      idle();
      bus.rs2_sel = 2;
      wb(2, 32'hA5A5);
      #1;
`ifdef SCALAR_RF_BYPASS_EN
      chk("r2_bypass_data", bus.rs2_data, 32'hA5A5);
      chk("r2_bypass_busy", {31'b0, bus.rs2_busy}, 32'h0);
`else
      chk("r2_bypass_data", bus.rs2_data, 32'h0);
      chk("r2_bypass_busy", {31'b0, bus.rs2_busy}, 32'h1);
`endif
      tick();
      idle();
      #1;
      chk("r2_data", bus.rs2_data, 32'hA5A5);

      // Register 0: writeback and dispatch ignored
      wb(0, 32'hFFFF_FFFF);
      disp(0, 1'b0);
      tick();
      idle();
      bus.rs1_sel = 0;
      #1;
      chk("r0_no_stale", {31'b0, bus.stale_drop}, 32'h0);
      chk("r0_not_busy", bus.busy_mask, 32'h0);
      chk("r0_reads_zero", bus.rs1_data, 32'h0);

      // Dispatch discarded by same-cycle mispredict
      disp(6, 1'b0);
      bus.branch_mispredict = 1'b1;
      tick();
      idle();
      chk("r6_disp_discard", bus.busy_mask, 32'h0);

      // Mid-operation reset overrides a pending dispatch and writeback
      disp(10, 1'b0);
      tick();
      idle();
      chk("r10_busy", bus.busy_mask, 32'h0000_0400);
      RST = 1'b1;
      wb(10, 32'h1234);
      disp(11, 1'b0);
      tick();
      RST = 1'b0;
      idle();
      bus.rs1_sel = 5;
      bus.rs2_sel = 10;
      #1;
      chk("rst_mask", bus.busy_mask, 32'h0);
      chk("rst_r5", bus.rs1_data, 32'h0);
      chk("rst_r10", bus.rs2_data, 32'h0);
      chk("rst_stale", {31'b0, bus.stale_drop}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
